// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared definitions for the BCD conversion controller.
// Holds the FSM state encoding and the double-dabble cell constants.
// IDLE=0, CONV=1, DONE=2. The encoding 2'd3 is illegal and recovers to IDLE.
package bcd_convert_ctrl_pkg;

  localparam int BCD_DIGIT_W = 4;

  // A digit at or above this value is corrected before the shift. Adding 3
  // first makes the shift (a doubling) carry into the next digit at the
  // right point.
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_OFFSET = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Request/result bundle between the ALU result register and the converter.
//
// Handshake: the master raises start with bin_in and signed_mode valid.
// The request is accepted on a rising edge when the converter is not busy
// (IDLE or DONE). A start seen while busy is dropped, not queued. busy is
// high from the cycle after acceptance until completion. done is a
// one-cycle pulse marking that bcd_out and sign were just updated. Both
// results then hold until the next completion.
//
// Signals:
//   start       request a conversion
//   signed_mode 1 = bin_in is two's complement
//   bin_in      value to convert
//   busy        conversion in progress
//   done        single-cycle completion pulse
//   sign        1 = captured value was negative
//   bcd_out     packed BCD, digit 0 in [3:0]
interface bcd_convert_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic                  signed_mode;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start, signed_mode, bin_in,
    input  busy, done, sign, bcd_out
  );

  modport slave (
    input  start, signed_mode, bin_in,
    output busy, done, sign, bcd_out
  );

endinterface

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction cell for a single BCD digit.
// Combinational. Values of 5 or more get 3 added; all other values pass
// through unchanged.
// Ports:
//   din   4-bit BCD digit before correction
//   dout  4-bit corrected digit
module bcd_add3_cell
  import bcd_convert_ctrl_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? (din + ADD3_OFFSET) : din;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential double-dabble binary-to-BCD converter.
// Runs one correct-then-shift iteration per clock, giving WIDTH iterations
// per conversion. In signed mode a negative input becomes sign plus
// magnitude.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        slave side of bcd_convert_ctrl_if (start/bin_in in; busy,
//              done, sign and bcd_out out, all registered)
//   fsm_state  current FSM state, for observation
module bcd_convert_ctrl
  import bcd_convert_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_convert_ctrl_if.slave   bus,
  output state_t              fsm_state
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  generate
    if (WIDTH < 2) begin : g_chk_width
      $error("bcd_convert_ctrl: WIDTH must be >= 2");
    end
    if ((64'd10 ** DIGITS) <= (64'd1 << WIDTH)) begin : g_chk_digits
      $error("bcd_convert_ctrl: DIGITS too small, need 10^DIGITS > 2^WIDTH");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_chk_cnt
      $error("bcd_convert_ctrl: CNT_W too small, need 2^CNT_W > WIDTH");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_sr;
  logic [WIDTH-1:0]   bin_sr;
  logic               sign_r;

  logic [BCD_W-1:0]   bcd_corr;
  logic [BCD_W-1:0]   bcd_next;
  logic [WIDTH-1:0]   mag;
  logic               neg;
  logic               last_iter;
  logic               unused_corr_msb;

  // One correction cell per digit. All cells act on the current BCD field
  // before that field shifts.
  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .din  (bcd_sr  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Shift the corrected field left by one and feed in the binary MSB.
  // 10^DIGITS > 2^WIDTH, so the top bit is never set before the shift.
  // Dropping it therefore loses nothing.
  assign bcd_next        = {bcd_corr[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign unused_corr_msb = bcd_corr[BCD_W-1];

  // Unary minus wraps at WIDTH bits. The most negative input maps to itself,
  // which read as unsigned is the correct magnitude (-128 -> 128).
  assign neg       = bus.signed_mode & bus.bin_in[WIDTH-1];
  assign mag       = neg ? -bus.bin_in : bus.bin_in;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bcd_sr      <= '0;
      bin_sr      <= '0;
      sign_r      <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.sign    <= 1'b0;
      bus.bcd_out <= '0;
    end else begin
      case (state)
        // DONE accepts a new request exactly as IDLE does, so back-to-back
        // conversions need no gap cycle.
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bcd_sr   <= '0;
            bin_sr   <= mag;
            sign_r   <= neg;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= CONV;
          end else begin
            state    <= IDLE;
          end
        end
        CONV: begin
          bcd_sr <= bcd_next;
          bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            bus.bcd_out <= bcd_next;
            bus.sign    <= sign_r;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
